ident_scanner: RTL
==================

// Module: ident_scanner
// PURPOSE
//  Streaming lexer: one 8-bit char per accepted cycle; finds tokens of form
//  [letter]+([letter]|[digit])*[digit], terminated by a separator char.
//  Second-gen identifier FSM: valid gating, length tracking/limit,
//  strict/loose start rules, token counting and per-token report pulse.
//  Sits between the char source (UART/ROM reader) and the symbol-table logic.
// PARAMETERS
//  MAX_LEN    16  longest reportable token (chars), >=2
//  LEN_W      5   width of length outputs, must hold MAX_LEN
//  CNT_W      8   width of token counter (wraps)
//  UNDERSCORE 0   1: '_' is classed as letter
//  STRICT     0   1: letter directly after digit-led run does not start a token
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      in_char is accepted this cycle
//  in_char    in   8      ASCII char
//  match      out  1      level: state==DIGIT (current run is a valid token so far)
//  cur_len    out  LEN_W  length of current run, saturates at MAX_LEN
//  tok_valid  out  1      1-cycle pulse: token completed
//  tok_len    out  LEN_W  length of completed token, held until next tok_valid
//  tok_drop   out  1      1-cycle pulse: token completed but exceeded MAX_LEN
//  tok_count  out  CNT_W  number of tok_valid pulses, mod 2^CNT_W
// BEHAVIOUR
//  One clk; reset sync active-high; reset wins over in_valid in the same cycle.
//  Reset: state=IDLE, cur_len=0, tok_len=0, tok_count=0, tok_valid=0, tok_drop=0,
//   too_long=0. Reset mid-token discards the token, no pulse.
//  Classes: L='a'-'z','A'-'Z' (+'_' if UNDERSCORE); D='0'-'9'; S=all others.
//  in_valid=0: state, cur_len, too_long held; tok_valid/tok_drop=0 next cycle.
//  All transitions below occur on clk edge with in_valid=1:
//   IDLE : L->ALPHA, cur_len=1 | D->(STRICT?SKIP:IDLE), cur_len=0 | S->IDLE
//   ALPHA: L->ALPHA, len+1 | D->DIGIT, len+1 | S->IDLE, cur_len=0, no report
//   DIGIT: L->ALPHA, len+1 | D->DIGIT, len+1 | S->IDLE, cur_len=0, report
//   SKIP : L,D->SKIP | S->IDLE (STRICT=0 never enters SKIP)
//  len+1: if cur_len==MAX_LEN, cur_len holds MAX_LEN and too_long<=1.
//  Report (DIGIT + S): registered, visible the cycle after the separator edge:
//   too_long=0: tok_valid=1, tok_len=cur_len, tok_count+=1 (wraps to 0)
//   too_long=1: tok_drop=1, tok_len and tok_count unchanged
//  too_long clears whenever state enters IDLE or SKIP.
//  match is decoded from the state register (no input path); 1 only in DIGIT.
//  A token is never reported without a terminating S char (end of stream
//   leaves it pending in DIGIT).
//  Back-to-back separators / tokens at full rate: no lost reports.
// TESTING
//  1 "ab12 " full rate -> match=1 after '1','2'; tok_valid 1 cycle after ' ',
//    tok_len=4, tok_count=1.
//  2 "ab1c " -> no tok_valid, tok_count=0; "x9 y7 " -> two pulses, lengths 2,2.
//  3 in_valid toggled 0/1 during "q5 " -> identical result to full rate, len=2.
//  4 "9ab1 ": STRICT=0 -> tok_len=3; STRICT=1 -> no pulse, state back to IDLE.
//  5 MAX_LEN=4, "abcde1 " -> cur_len stops at 4, tok_drop pulse, tok_count
//    unchanged; then "a1 " -> tok_valid, tok_len=2.
//  6 reset after "ab1" then " " -> no pulse; CNT_W=2 with 4 tokens -> tok_count=0.

Source files
------------

// File: rtl/ident_scanner_if.sv
// Character stream in, token reports out, between the char source and symbol-table logic.
interface ident_scanner_if #(
    parameter int unsigned LEN_W = 5,
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic [7:0]       in_char;
    logic             match;
    logic [LEN_W-1:0] cur_len;
    logic             tok_valid;
    logic [LEN_W-1:0] tok_len;
    logic             tok_drop;
    logic [CNT_W-1:0] tok_count;

    modport master (
        output in_valid, in_char,
        input  match, cur_len, tok_valid, tok_len, tok_drop, tok_count
    );

    modport slave (
        input  in_valid, in_char,
        output match, cur_len, tok_valid, tok_len, tok_drop, tok_count
    );
endinterface

// File: rtl/ident_scanner.sv
// Streaming identifier lexer: tracks [letter]+([letter]|[digit])*[digit] runs and
// reports each one when a separator char closes it.
module ident_scanner #(
    parameter int unsigned MAX_LEN    = 16,
    parameter int unsigned LEN_W      = 5,
    parameter int unsigned CNT_W      = 8,
    parameter bit          UNDERSCORE = 1'b0,
    parameter bit          STRICT     = 1'b0
) (
    input logic           clk,
    input logic           reset,
    ident_scanner_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAlpha, StDigit, StSkip} state_e;

    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_LEN);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cur_len_q, cur_len_d;
    logic [LEN_W-1:0] tok_len_q, tok_len_d;
    logic [CNT_W-1:0] tok_count_q, tok_count_d;
    logic             too_long_q, too_long_d;
    logic             tok_valid_q, tok_valid_d;
    logic             tok_drop_q, tok_drop_d;
    logic             is_letter, is_digit;
    logic             len_sat;
    logic [LEN_W-1:0] len_inc;

    always_comb begin
        is_letter = (bus.in_char >= 8'h61 && bus.in_char <= 8'h7a) ||
                    (bus.in_char >= 8'h41 && bus.in_char <= 8'h5a) ||
                    (UNDERSCORE && bus.in_char == 8'h5f);
        is_digit  = (bus.in_char >= 8'h30 && bus.in_char <= 8'h39);
    end

    // Length saturates at MAX_LEN; growing past it marks the run as unreportable.
    assign len_sat = (cur_len_q == MaxLen);
    assign len_inc = len_sat ? MaxLen : cur_len_q + LEN_W'(1);

    always_comb begin
        state_d     = state_q;
        cur_len_d   = cur_len_q;
        too_long_d  = too_long_q;
        tok_len_d   = tok_len_q;
        tok_count_d = tok_count_q;
        tok_valid_d = 1'b0;
        tok_drop_d  = 1'b0;
        if (bus.in_valid) begin
            unique case (state_q)
                StIdle: begin
                    too_long_d = 1'b0;
                    if (is_letter) begin
                        state_d   = StAlpha;
                        cur_len_d = LEN_W'(1);
                    end else begin
                        state_d   = (is_digit && STRICT) ? StSkip : StIdle;
                        cur_len_d = '0;
                    end
                end
                StAlpha, StDigit: begin
                    if (is_letter || is_digit) begin
                        state_d   = is_digit ? StDigit : StAlpha;
                        cur_len_d = len_inc;
                        if (len_sat) too_long_d = 1'b1;
                    end else begin
                        state_d    = StIdle;
                        cur_len_d  = '0;
                        too_long_d = 1'b0;
                        if (state_q == StDigit) begin
                            if (too_long_q) begin
                                tok_drop_d = 1'b1;
                            end else begin
                                tok_valid_d = 1'b1;
                                tok_len_d   = cur_len_q;
                                tok_count_d = tok_count_q + CNT_W'(1);
                            end
                        end
                    end
                end
                StSkip: begin
                    too_long_d = 1'b0;
                    cur_len_d  = '0;
                    if (!is_letter && !is_digit) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cur_len_q   <= '0;
            too_long_q  <= 1'b0;
            tok_valid_q <= 1'b0;
            tok_drop_q  <= 1'b0;
            tok_len_q   <= '0;
            tok_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cur_len_q   <= cur_len_d;
            too_long_q  <= too_long_d;
            tok_valid_q <= tok_valid_d;
            tok_drop_q  <= tok_drop_d;
            tok_len_q   <= tok_len_d;
            tok_count_q <= tok_count_d;
        end
    end

    assign bus.match     = (state_q == StDigit);
    assign bus.cur_len   = cur_len_q;
    assign bus.tok_valid = tok_valid_q;
    assign bus.tok_len   = tok_len_q;
    assign bus.tok_drop  = tok_drop_q;
    assign bus.tok_count = tok_count_q;
endmodule
